// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: default field sizes, evaluator state encoding
// and the primitive polynomial used for modular reduction.
package gf_pkg;

    localparam int GF_M    = 255;
    localparam int GF_SIZE = 8;

    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^SIZE) multiplier: shift-and-add with on-the-fly
// reduction by the primitive polynomial.
module gf_mul
    import gf_pkg::*;
#(
    parameter int m    = GF_M,
    parameter int SIZE = $clog2(m)
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    output logic [SIZE-1:0] y_o
);

    localparam logic [SIZE-1:0] RED = SIZE'(GF_PRIM_POLY);

    logic [SIZE-1:0] prod_s;
    logic [SIZE-1:0] sh_s;

    // Accumulate a*x^i for every set bit of b, reducing a*x^i as it grows.
    always_comb begin
        prod_s = '0;
        sh_s   = a_i;
        for (int i = 0; i < SIZE; i++) begin
            prod_s = prod_s ^ (b_i[i] ? sh_s : {SIZE{1'b0}});
            sh_s   = sh_s[SIZE-1] ? ({sh_s[SIZE-2:0], 1'b0} ^ RED)
                                  : {sh_s[SIZE-2:0], 1'b0};
        end
    end

    assign y_o = prod_s;

endmodule

// File: rtl/gf_poly_eval.sv
// Sequential Horner evaluator of an (n+1)-coefficient polynomial over
// GF(2^8), sharing one multiplier across n iterations.
module gf_poly_eval
    import gf_pkg::*;
#(
    parameter int m         = GF_M,
    parameter int SIZE      = $clog2(m),
    parameter int n         = 2,
    parameter int flat_size = (n + 1) * SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [flat_size-1:0] flat_p,
    input  logic [SIZE-1:0]      x,
    output logic                 busy,
    output logic                 done,
    output logic [SIZE-1:0]      result
);

    localparam int IDX_W = (n > 0) ? $clog2(n + 1) : 1;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SIZE-1:0]        x_q, x_d;
    logic [flat_size-1:0]   p_q, p_d;
    logic [SIZE-1:0]        result_q, result_d;
    logic                   busy_q;
    logic                   done_q;
    logic [SIZE-1:0]        mul_s;
    logic [SIZE-1:0]        coef_s [0:n];

    for (genvar g = 0; g <= n; g++) begin : g_unflat
        assign coef_s[g] = p_q[g*SIZE +: SIZE];
    end

    gf_mul #(
        .m    (m),
        .SIZE (SIZE)
    ) u_gf_mul (
        .a_i (acc_q),
        .b_i (x_q),
        .y_o (mul_s)
    );

    // Next-state logic: operand capture in IDLE, one Horner step per RUN cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        x_d      = x_q;
        p_d      = p_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d   = flat_p;
                    x_d   = x;
                    acc_d = flat_p[n*SIZE +: SIZE];
                    if (n == 0) begin
                        idx_d    = '0;
                        result_d = flat_p[0 +: SIZE];
                        state_d  = ST_DONE;
                    end else begin
                        idx_d   = IDX_W'(n - 1);
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = mul_s ^ coef_s[idx_q];
                if (idx_q == '0) begin
                    result_d = acc_d;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done follow the next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            x_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            p_q      <= p_d;
            result_q <= result_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_gf_poly_eval.sv
// Scoreboard bench for gf_poly_eval: the driver queues expected results,
// a negedge monitor checks each done pulse against them.
module tb_gf_poly_eval;

    localparam int SIZE = 8;
    localparam int N    = 2;
    localparam int FW   = (N + 1) * SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [FW-1:0]   flat_p = '0;
    logic [SIZE-1:0] x = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q [$];
    int         cyc_q [$];

    int exp_t [0:254];
    int log_t [0:255];

    gf_poly_eval #(.n(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flat_p (flat_p),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference multiply via discrete log tables of the 0x11D field.
    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic int peval(input int c0, input int c1, input int c2, input int xv);
        int coef [3];
        int y, xp;
        coef[0] = c0; coef[1] = c1; coef[2] = c2;
        y = 0; xp = 1;
        for (int i = 0; i < 3; i++) begin
            y  = y ^ gmul(coef[i], xp);
            xp = gmul(xp, xv);
        end
        return y;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: result=%0h with no evaluation pending", result);
            end else begin
                check("result", int'(result), int'(exp_q.pop_front()));
                check("done_cycle", cyc, cyc_q.pop_front());
            end
        end
    end

    // One evaluation: start for one edge, scramble inputs, then wait out n+2 cycles.
    task automatic issue(input int c2, input int c1, input int c0, input int xv,
                         input int expv, input bit scramble);
        @(negedge clk);
        flat_p = {c2[7:0], c1[7:0], c0[7:0]};
        x      = xv[7:0];
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(expv[7:0]);
        cyc_q.push_back(cyc + N);
        if (scramble) begin
            flat_p = {FW{1'b1}};
            x      = 8'hFF;
        end
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("busy", int'(busy), (i <= N) ? 1 : 0);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int e, c2, c1, c0, xv, c0cyc;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if (e & 32'h100) e = e ^ 32'h11D;
        end
        log_t[0] = 0;

        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset one cycle into an evaluation aborts it with no done pulse.
        @(negedge clk);
        flat_p = {8'h01, 8'h00, 8'h00};
        x      = 8'h80;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_result", int'(result), 0);

        issue(1, 0, 0, 8'h02, 8'h04, 1'b0);
        issue(1, 0, 0, 8'h80, 8'h13, 1'b0);
        issue(3, 2, 1, 8'h01, 8'h00, 1'b0);
        issue(3, 2, 1, 8'h00, 8'h01, 1'b0);
        issue(5, 5, 5, 8'h02, 8'h1B, 1'b1);
        check("result_held", int'(result), 8'h1B);

        // Start held high: only the edges seen in IDLE launch evaluations.
        @(negedge clk);
        flat_p = {8'h01, 8'h00, 8'h00};
        x      = 8'h02;
        start  = 1'b1;
        @(posedge clk);
        #1;
        c0cyc = cyc;
        exp_q.push_back(8'h04);
        cyc_q.push_back(c0cyc + N);
        exp_q.push_back(8'h13);
        cyc_q.push_back(c0cyc + N + (N + 2));
        x = 8'h80;
        repeat (N + 2) @(posedge clk);
        #1;
        start = 1'b0;
        x = 8'h02;
        drain();
        repeat (2) @(negedge clk);
        check("b2b_idle", int'(busy), 0);

        for (int k = 0; k < 30; k++) begin
            c2 = $urandom_range(0, 255);
            c1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            c0 = $urandom_range(0, 255);
            xv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(c2, c1, c0, xv, peval(c0, c1, c2, xv), k[0]);
        end

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
